// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Moore control FSM for a multicycle RV32I subset datapath
//               (lw, sw, R-type, I-type ALU, beq, jal). Sequences one shared
//               memory port and one ALU through fetch/decode/execute/writeback
//               and decodes the ALU operation from funct3/funct7.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [2:0] ALUControl,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [3:0] state
);

    localparam logic [6:0] c_OP_LW   = 7'h03;
    localparam logic [6:0] c_OP_SW   = 7'h23;
    localparam logic [6:0] c_OP_R    = 7'h33;
    localparam logic [6:0] c_OP_I    = 7'h13;
    localparam logic [6:0] c_OP_JAL  = 7'h6F;
    localparam logic [6:0] c_OP_BEQ  = 7'h63;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_pcupdate;
    logic       w_branch;
    logic       w_irwrite;
    logic       w_memwrite;
    logic       w_regwrite;
    logic [1:0] w_aluop;

    // State register; reset snaps straight back to FETCH, even mid-instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Next-state logic; unknown opcodes and unused encodings fall back to FETCH
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_R:           w_next = S_EXECUTER;
                    c_OP_I:           w_next = S_EXECUTEI;
                    c_OP_JAL:         w_next = S_JAL;
                    c_OP_BEQ:         w_next = S_BEQ;
                    default:          w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = (op == c_OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = S_MEMWB;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_JAL:      w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    // Moore outputs per state; anything not driven in a state stays 0
    always_comb begin
        w_pcupdate = 1'b0;
        w_branch   = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_aluop    = 2'b00;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_irwrite  = 1'b1;
                w_pcupdate = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
            end
            S_DECODE: begin
                // OldPC + immediate: branch target ready before BEQ compares
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                w_aluop = 2'b10;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_aluop = 2'b10;
            end
            S_JAL: begin
                // Link value OldPC + 4 computed while PC takes the jump target
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                w_pcupdate = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                w_aluop  = 2'b01;
                w_branch = 1'b1;
            end
            default: begin
                w_pcupdate = 1'b0;
            end
        endcase
    end

    // ALU decoder shared with the single-cycle control encoding
    always_comb begin
        ALUControl = 3'b000;
        case (w_aluop)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            default: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
        endcase
    end

    // Immediate format depends only on the opcode, in every state
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            c_OP_SW:  ImmSrc = 2'b01;
            c_OP_BEQ: ImmSrc = 2'b10;
            c_OP_JAL: ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    // Write enables are suppressed while reset is held; state is FETCH then,
    // so every other output already shows its FETCH value
    assign PCWrite  = (w_pcupdate | (w_branch & Zero)) & ~reset;
    assign IRWrite  = w_irwrite  & ~reset;
    assign MemWrite = w_memwrite & ~reset;
    assign RegWrite = w_regwrite & ~reset;
    assign state    = r_state;

endmodule
`default_nettype wire
